mem_array_ctrl: RTL and testbench

//  Downstream consumer of the op/select control FSM: takes its valid/rw command outputs and

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_array_ctrl_if.sv | 31 +++
 rtl/mem_word.sv | 29 ++
 rtl/mem_array_ctrl.sv | 108 ++++++++++
 tb/tb_mem_array_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-array controller.
//   state_e  : access sequencer states (IDLE -> PRE -> ACC -> DONE -> IDLE)
//   RW_READ  : rw encoding for a read command
//   RW_WRITE : rw encoding for a write command
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_array_ctrl_if.sv
// Command/response bundle between the control FSM (master) and the array controller (slave).
//   valid/rw/addr/wdata      : command from the control FSM
//   rdata/rdata_valid        : read data and its 1-cycle update strobe
//   wr_done                  : 1-cycle write-committed strobe
//   busy/overrun             : sequencer occupied / command edge dropped while occupied
interface mem_array_ctrl_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
) ();

  logic              valid;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              wr_done;
  logic              busy;
  logic              overrun;

  modport master (
    output valid, rw, addr, wdata,
    input  rdata, rdata_valid, wr_done, busy, overrun
  );

  modport slave (
    input  valid, rw, addr, wdata,
    output rdata, rdata_valid, wr_done, busy, overrun
  );

endinterface

// File: rtl/mem_word.sv
// One storage word of the array.
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear
//   we    : write enable
//   d     : write data
//   q     : stored word
module mem_word #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (we) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mem_array_ctrl.sv
// Executes read/write commands from the control FSM on a small word array.
// Each accepted command runs PRE (precharge, idle) -> ACC (array access) -> DONE (strobe).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of mem_array_ctrl_if (command in, data/strobes/status out)
module mem_array_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WORDS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  mem_array_ctrl_if.slave   bus
);

  state_e            r_state;
  logic              r_valid_q;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_wr_done;
  logic              r_busy;
  logic              r_overrun;

  logic              w_cmd;
  logic [WORDS-1:0]  w_we;
  logic [DATA_W-1:0] w_words [WORDS];

  // A held-high valid produces exactly one command.
  assign w_cmd = bus.valid & ~r_valid_q;

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    assign w_we[i] = (r_state == ACC) && (r_rw == RW_WRITE) && (r_addr == ADDR_W'(i));

    mem_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .we    (w_we[i]),
      .d     (r_wdata),
      .q     (w_words[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_valid_q     <= 1'b0;
      r_rw          <= RW_WRITE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_wr_done     <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_valid_q     <= bus.valid;
      r_rdata_valid <= 1'b0;
      r_wr_done     <= 1'b0;
      // Any command edge outside IDLE is dropped, including the DONE->IDLE cycle.
      r_overrun     <= w_cmd && (r_state != IDLE);

      unique case (r_state)
        IDLE: begin
          if (w_cmd) begin
            r_rw    <= bus.rw;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_state <= PRE;
            r_busy  <= 1'b1;
          end
        end
        PRE: begin
          r_state <= ACC;
        end
        ACC: begin
          if (r_rw == RW_READ) begin
            r_rdata <= w_words[r_addr];
          end
          r_state <= DONE;
        end
        DONE: begin
          r_rdata_valid <= (r_rw == RW_READ);
          r_wr_done     <= (r_rw == RW_WRITE);
          r_state       <= IDLE;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.wr_done     = r_wr_done;
  assign bus.busy        = r_busy;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Directed + randomized bench for mem_array_ctrl with a behavioural array model.
module tb_mem_array_ctrl;
  import mem_pkg::*;

  logic clk;
  logic reset;

  mem_array_ctrl_if #(.ADDR_W(2), .DATA_W(8)) bus ();

  mem_array_ctrl #(
    .ADDR_W (2),
    .DATA_W (8),
    .WORDS  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Behavioural model: storage contents and the last value returned by a read.
  logic [7:0] model_mem [4];
  logic [7:0] model_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
    model_rdata = 8'h00;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd0);
    chk({tag, "_wdone"}, 32'(bus.wr_done), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'(model_rdata));
  endtask

  // One complete command; inputs are scrambled right after capture, which must not matter.
  task automatic do_cmd(input logic c_rw, input logic [1:0] c_addr, input logic [7:0] c_data,
                        input string tag);
    bus.valid = 1'b1;
    bus.rw    = c_rw;
    bus.addr  = c_addr;
    bus.wdata = c_data;
    step();                                  // command edge N
    bus.valid = 1'b0;
    bus.rw    = 1'($urandom);
    bus.addr  = 2'($urandom);
    bus.wdata = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_early_strobe"}, 32'(bus.rdata_valid | bus.wr_done), 32'd0);
      chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
      step();
    end
    // After edge N+3: strobe cycle.
    if (c_rw == RW_READ) begin
      model_rdata = model_mem[c_addr];
      chk({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd1);
      chk({tag, "_wdone"}, 32'(bus.wr_done), 32'd0);
    end else begin
      model_mem[c_addr] = c_data;
      chk({tag, "_wdone"}, 32'(bus.wr_done), 32'd1);
      chk({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd0);
    end
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'(model_rdata));
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    step();
    chk_idle_outputs({tag, "_after"});
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int ovr_cnt;
    logic       r_rw;
    logic [1:0] r_a;
    logic [7:0] r_d;

    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    bus.valid = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 8'd0;
    model_reset();

    // 1: reset state, then reset asserted mid-access.
    step();
    chk_idle_outputs("por");
    reset = 1'b1;
    step();
    do_cmd(RW_WRITE, 2'd3, 8'h5A, "pre_rst_wr");
    do_cmd(RW_READ, 2'd3, 8'h00, "pre_rst_rd");
    bus.valid = 1'b1; bus.rw = RW_WRITE; bus.addr = 2'd1; bus.wdata = 8'h77;
    step();
    bus.valid = 1'b0;
    step();                                  // sequencer now in ACC
    reset = 1'b0;
    #1;
    model_reset();
    chk_idle_outputs("midrst");
    #3 reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) do_cmd(RW_READ, 2'(i), 8'h00, "rst_rd");

    // 2: write then read back.
    do_cmd(RW_WRITE, 2'd2, 8'hA5, "wr_a5");
    step();
    do_cmd(RW_READ, 2'd2, 8'h00, "rd_a5");

    // 3: valid held high for 10 cycles issues exactly one write.
    busy_cnt = 0; done_cnt = 0; ovr_cnt = 0;
    bus.valid = 1'b1; bus.rw = RW_WRITE; bus.addr = 2'd1; bus.wdata = 8'h3C;
    for (int k = 0; k < 13; k++) begin
      if (k == 10) bus.valid = 1'b0;
      step();
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.wr_done);
      ovr_cnt  += int'(bus.overrun);
    end
    model_mem[1] = 8'h3C;
    chk("hold_busy_cycles", 32'(busy_cnt), 32'd3);
    chk("hold_wr_done_count", 32'(done_cnt), 32'd1);
    chk("hold_overrun_count", 32'(ovr_cnt), 32'd0);
    do_cmd(RW_READ, 2'd1, 8'h00, "rd_3c");

    // 4: second command edge two cycles after the first is an overrun.
    bus.valid = 1'b1; bus.rw = RW_WRITE; bus.addr = 2'd0; bus.wdata = 8'h11;
    step();                                  // edge N: accepted
    bus.valid = 1'b0;
    step();                                  // edge N+1
    bus.valid = 1'b1; bus.wdata = 8'h22;
    step();                                  // edge N+2: dropped
    chk("ovr_pulse", 32'(bus.overrun), 32'd1);
    bus.valid = 1'b0;
    step();                                  // edge N+3
    chk("ovr_pulse_width", 32'(bus.overrun), 32'd0);
    chk("ovr_wr_done", 32'(bus.wr_done), 32'd1);
    model_mem[0] = 8'h11;
    step();
    do_cmd(RW_READ, 2'd0, 8'h00, "rd_11");

    // 6: all addresses back-to-back, reset before reading addr 3.
    for (int i = 0; i < 4; i++) do_cmd(RW_WRITE, 2'(i), 8'h10 + 8'(i), "b2b_wr");
    for (int i = 0; i < 3; i++) do_cmd(RW_READ, 2'(i), 8'h00, "b2b_rd");
    reset = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
    step();
    do_cmd(RW_READ, 2'd3, 8'h00, "rd_after_rst");

    // Randomized traffic against the model (5 also covered: inputs scrambled after capture).
    for (int n = 0; n < 30; n++) begin
      r_rw = 1'($urandom);
      r_a  = 2'($urandom);
      r_d  = 8'($urandom);
      do_cmd(r_rw, r_a, r_d, "rand");
      if (($urandom % 2) == 0) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
